// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: NUM_CH input lanes and one registered output lane.
// The in_last/out_last signals exist only when STREAM_MUX_LOCK_EN is defined.
interface stream_mux_rr_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) ();
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;
`ifdef STREAM_MUX_LOCK_EN
  logic [NUM_CH-1:0]        in_last;
  logic                     out_last;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );
  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );
`else
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux, fixed-select or round-robin, with a one-beat registered output stage.
// Define STREAM_MUX_LOCK_EN to add packet locking (in_last/out_last) in round-robin mode.
module stream_mux_rr #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_mux_rr_if.master  bus
);

  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic              load;
  logic              xfer;
  logic              advance;
  logic              locked;
  int unsigned       idx;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

`ifdef STREAM_MUX_LOCK_EN
  typedef enum logic {LK_FREE, LK_HELD} lock_e;
  lock_e lock_q, lock_d;
  logic  gnt_last;
  logic  out_last_q, out_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= LK_FREE;
    else        lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    if (!mode)     lock_d = LK_FREE;
    else if (xfer) lock_d = gnt_last ? LK_FREE : LK_HELD;
  end

  // Lock only steers arbitration in round-robin mode; out_ch_q is the locked channel.
  always_comb begin
    locked = mode && (lock_q == LK_HELD);
  end

  assign advance      = gnt_last;
  assign bus.out_last = out_last_q;
`else
  assign locked  = 1'b0;
  assign advance = 1'b1;
`endif

  always_comb begin
    grant = '0;
    idx   = 0;
    if (!mode) begin
      if (32'(sel) < NUM_CH) grant[sel] = 1'b1;
    end else if (locked) begin
      grant[out_ch_q] = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        idx = (32'(rr_ptr_q) + k) % NUM_CH;
        if (grant == '0 && bus.in_valid[idx]) grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
`ifdef STREAM_MUX_LOCK_EN
    gnt_last = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        gnt_idx  = SEL_W'(i);
        gnt_data = bus.in_data[i*DATA_W +: DATA_W];
`ifdef STREAM_MUX_LOCK_EN
        gnt_last = bus.in_last[i];
`endif
      end
    end
  end

  assign load         = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = grant & {NUM_CH{load}};
  assign xfer         = |(bus.in_valid & bus.in_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_LOCK_EN
    out_last_d  = out_last_q;
`endif
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = gnt_data;
        out_ch_d   = gnt_idx;
`ifdef STREAM_MUX_LOCK_EN
        out_last_d = gnt_last;
`endif
      end
    end
    if (mode && xfer && advance)
      rr_ptr_d = (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
`ifdef STREAM_MUX_LOCK_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_LOCK_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: vector table, directed corner sequences and a random
// phase checked against a transaction-level reference model plus a beat scoreboard.
`timescale 1ns/1ps
module tb_stream_mux_rr;
  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = $clog2(N);
  localparam int unsigned N6  = 6;
  localparam int unsigned SW6 = $clog2(N6);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode, mode6;
  logic [SW-1:0]  sel;
  logic [SW6-1:0] sel6;
  int             checks = 0;
  int             errors = 0;

  stream_mux_rr_if #(.NUM_CH(N),  .DATA_W(DW)) bus  ();
  stream_mux_rr_if #(.NUM_CH(N6), .DATA_W(DW)) bus6 ();

  stream_mux_rr #(.NUM_CH(N), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(bus));
  stream_mux_rr #(.NUM_CH(N6), .DATA_W(DW)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6), .bus(bus6));

  always #5 clk = ~clk;

  // Reference model: the beat held in the output register plus arbitration bookkeeping.
  bit              m_valid;
  logic [DW-1:0]   m_data;
  int              m_ch;
  int              m_ptr;
  bit              m_lock;
  int              m_lock_ch;
  bit              m_last;

  typedef struct { int ch; logic [DW-1:0] data; } beat_t;
  beat_t sb[$];

  typedef struct {
    logic mode; logic [SW-1:0] sel; logic [N-1:0] valid; logic ordy;
    logic [N-1:0] e_ready; logic e_valid; logic [SW-1:0] e_ch; logic [DW-1:0] e_data;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
    m_lock = 0; m_lock_ch = 0; m_last = 0;
    sb.delete();
  endtask

  function automatic int winner();
    if (!mode) return (int'(sel) < N) ? int'(sel) : -1;
    if (m_lock) return m_lock_ch;
    for (int k = 0; k < N; k++) begin
      if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = winner();
    if ((!m_valid || bus.out_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic [N-1:0]    vld;
    logic [N*DW-1:0] dat;
    bit              load;
    int              w;
    beat_t           b;
`ifdef STREAM_MUX_LOCK_EN
    logic [N-1:0]    lst;
`endif
    @(negedge clk);
    check("in_ready",  32'(bus.in_ready),  32'(exp_ready()));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data",  32'(bus.out_data),  32'(m_data));
    check("out_ch",    32'(bus.out_ch),    32'(m_ch));
`ifdef STREAM_MUX_LOCK_EN
    check("out_last",  32'(bus.out_last),  32'(m_last));
    lst = bus.in_last;
`endif
    if (bus.out_valid && bus.out_ready) begin
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("sb_ch",   32'(bus.out_ch),   32'(b.ch));
        check("sb_data", 32'(bus.out_data), 32'(b.data));
      end
    end
    for (int c = 0; c < N; c++) begin
      if (bus.in_valid[c] && bus.in_ready[c]) begin
        b.ch = c; b.data = bus.in_data[c*DW +: DW];
        sb.push_back(b);
      end
    end
    vld  = bus.in_valid;
    dat  = bus.in_data;
    load = !m_valid || bus.out_ready;
    w    = winner();
    @(posedge clk);
    if (!mode) m_lock = 0;
    if (load) begin
      if (w >= 0 && vld[w]) begin
        m_valid = 1; m_data = dat[w*DW +: DW]; m_ch = w;
`ifdef STREAM_MUX_LOCK_EN
        m_last = lst[w];
        if (mode) begin
          if (lst[w]) begin m_lock = 0; m_ptr = (w + 1) % N; end
          else begin m_lock = 1; m_lock_ch = w; end
        end
`else
        if (mode) m_ptr = (w + 1) % N;
`endif
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[1]  = '{1'b0, 2'd2, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[2]  = '{1'b0, 2'd0, 4'hF,    1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
    tbl[3]  = '{1'b0, 2'd0, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[4]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b1000, 1'b0, 2'd0, 8'h10};
    tbl[5]  = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[6]  = '{1'b1, 2'd0, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[7]  = '{1'b1, 2'd0, 4'hF,    1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[8]  = '{1'b1, 2'd0, 4'b1101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[9]  = '{1'b1, 2'd0, 4'b1101, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[10] = '{1'b1, 2'd0, 4'b1101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[11] = '{1'b1, 2'd0, 4'b1101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};

    rst_n = 1'b0; mode = 1'b0; sel = '0; mode6 = 1'b0; sel6 = '0;
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus6.in_valid = '0; bus6.in_data = '0; bus6.out_ready = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last = '1; bus6.in_last = '1;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_ch",    32'(bus.out_ch),    32'd0);
    rst_n = 1'b1;

    bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel;
      bus.in_valid = tbl[i].valid; bus.out_ready = tbl[i].ordy;
      #1;
      check("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[i].e_ready));
      cycle();
      check("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].e_valid));
      check("tbl_out_ch",    32'(bus.out_ch),    32'(tbl[i].e_ch));
      check("tbl_out_data",  32'(bus.out_data),  32'(tbl[i].e_data));
    end

    // Backpressure: ch3 beat held for three stalled cycles, then ch0 follows.
    mode = 1'b1; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
    cycle();
    check("bp_first_ch", 32'(bus.out_ch), 32'd3);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      cycle();
      check("bp_hold_ch",   32'(bus.out_ch),   32'd3);
      check("bp_hold_data", 32'(bus.out_data), 32'h13);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_next_ch",   32'(bus.out_ch),   32'd0);
    check("bp_next_data", 32'(bus.out_data), 32'h10);

    for (int i = 0; i < 400; i++) begin
      mode = ($urandom_range(0, 9) != 0);
      sel = SW'($urandom_range(0, N - 1));
      bus.in_valid = N'($urandom);
      bus.in_data = ($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LOCK_EN
      bus.in_last = N'($urandom);
`endif
      cycle();
    end

    // Asynchronous reset while a beat is held.
    mode = 1'b1; bus.in_valid = 4'hF; bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.out_ready = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last = '1;
`endif
    cycle();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_data",  32'(bus.out_data),  32'd0);
    check("async_rst_ch",    32'(bus.out_ch),    32'd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
    end
    rst_n = 1'b1;
    bus.in_valid = 4'b0001;
    cycle();
    check("post_rst_ch", 32'(bus.out_ch), 32'd0);

`ifdef STREAM_MUX_LOCK_EN
    // ch1 sends a 3-beat packet while ch0 and ch2 stay valid.
    bus.in_valid = 4'b0111; bus.in_last = 4'b0000;
    cycle();
    check("lk_b1_ch", 32'(bus.out_ch), 32'd1);
    check("lk_b1_last", 32'(bus.out_last), 32'd0);
    #1;
    check("lk_ready_held", 32'(bus.in_ready), 32'b0010);
    cycle();
    check("lk_b2_ch", 32'(bus.out_ch), 32'd1);
    check("lk_b2_last", 32'(bus.out_last), 32'd0);
    bus.in_last = 4'b0010;
    cycle();
    check("lk_b3_ch", 32'(bus.out_ch), 32'd1);
    check("lk_b3_last", 32'(bus.out_last), 32'd1);
    cycle();
    check("lk_next_ch", 32'(bus.out_ch), 32'd2);
    check("lk_next_last", 32'(bus.out_last), 32'd0);
    mode = 1'b0; sel = 2'd0; bus.in_last = '1;
    cycle();
    check("lk_mode0_ch", 32'(bus.out_ch), 32'd0);
`endif

    // Six-channel instance: last legal select, then out-of-range selects.
    mode6 = 1'b0; sel6 = 3'd1; bus6.in_valid = '1; bus6.out_ready = 1'b1;
    bus6.in_data = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    @(posedge clk); #1;
    check("n6_sel1_valid", 32'(bus6.out_valid), 32'd1);
    check("n6_sel1_ch",    32'(bus6.out_ch),    32'd1);
    sel6 = 3'd5;
    #1;
    check("n6_sel5_ready", 32'(bus6.in_ready), 32'b100000);
    @(posedge clk); #1;
    check("n6_sel5_data", 32'(bus6.out_data), 32'h15);
    sel6 = 3'd6;
    #1;
    check("n6_sel6_ready", 32'(bus6.in_ready), 32'd0);
    sel6 = 3'd7;
    #1;
    check("n6_sel7_ready", 32'(bus6.in_ready), 32'd0);
    @(posedge clk); #1;
    check("n6_sel7_valid", 32'(bus6.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
